// File: rtl/stream_phase_monitor.sv
// Passive monitor for NUM_CH ready/valid token streams: per-channel WAIT/ARMED/ACTIVE/DONE
// lifecycle gated by dependency masks and gap counters, with saturating activity counters.
module stream_phase_monitor #(
    parameter int                    NUM_CH     = 4,
    parameter int                    DATA_WIDTH = 17,
    parameter int                    CNT_WIDTH  = 32,
    parameter int                    GAP_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] DONE_TOKEN = 17'h10100
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clk_en,
    input  logic                           flush,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
    input  logic [NUM_CH-1:0]              ch_valid,
    input  logic [NUM_CH-1:0]              ch_ready,
    input  logic [NUM_CH*NUM_CH-1:0]       dep_mask,
    input  logic [NUM_CH*GAP_WIDTH-1:0]    gap_cycles,
    input  logic [$clog2(NUM_CH)+1:0]      cnt_sel,
    output logic [CNT_WIDTH-1:0]           cnt_out,
    output logic [2*NUM_CH-1:0]            ch_state,
    output logic [NUM_CH-1:0]              ch_done,
    output logic                           all_done
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } ch_state_t;

    ch_state_t              state_r  [NUM_CH];
    ch_state_t              state_s  [NUM_CH];
    logic [CNT_WIDTH-1:0]   active_r [NUM_CH];
    logic [CNT_WIDTH-1:0]   active_s [NUM_CH];
    logic [CNT_WIDTH-1:0]   xfer_r   [NUM_CH];
    logic [CNT_WIDTH-1:0]   xfer_s   [NUM_CH];
    logic [CNT_WIDTH-1:0]   stall_r  [NUM_CH];
    logic [CNT_WIDTH-1:0]   stall_s  [NUM_CH];
    logic [GAP_WIDTH-1:0]   gap_r    [NUM_CH];
    logic [GAP_WIDTH-1:0]   gap_s    [NUM_CH];
    logic [NUM_CH-1:0]      sat_r;
    logic [NUM_CH-1:0]      sat_s;
    logic [NUM_CH-1:0]      done_vec_s;
    logic [NUM_CH-1:0]      deps_ok_s;
    logic [NUM_CH-1:0]      count_en_s;
    logic [NUM_CH-1:0]      fin_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value,
                                                     input logic                 en);
        if (en && !(&value)) begin
            sat_inc = value + CNT_WIDTH'(1);
        end else begin
            sat_inc = value;
        end
    endfunction

    // Decode per-channel state registers onto the status outputs
    always_comb begin
        ch_state   = '0;
        done_vec_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_state[2*i +: 2] = state_r[i];
            done_vec_s[i]      = (state_r[i] == ST_DONE);
        end
        ch_done  = done_vec_s;
        all_done = &done_vec_s;
    end

    // Dependency satisfaction from pre-edge states only; the diagonal mask bit is ignored
    always_comb begin
        deps_ok_s = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                deps_ok_s[i] = deps_ok_s[i] &
                               ((i == j) | ~dep_mask[i*NUM_CH + j] | done_vec_s[j]);
            end
        end
    end

    // Next-state and counter update for every channel
    always_comb begin
        count_en_s = '0;
        fin_s      = '0;
        sat_s      = sat_r;
        for (int i = 0; i < NUM_CH; i++) begin
            state_s[i]  = state_r[i];
            gap_s[i]    = gap_r[i];
            active_s[i] = active_r[i];
            xfer_s[i]   = xfer_r[i];
            stall_s[i]  = stall_r[i];

            count_en_s[i] = ((state_r[i] == ST_ARMED) & ch_valid[i]) | (state_r[i] == ST_ACTIVE);
            fin_s[i]      = ch_valid[i] & ch_ready[i] &
                            (ch_data[i*DATA_WIDTH +: DATA_WIDTH] == DONE_TOKEN);

            case (state_r[i])
                ST_WAIT: begin
                    if (!deps_ok_s[i]) begin
                        gap_s[i] = gap_cycles[i*GAP_WIDTH +: GAP_WIDTH];
                    end else if (gap_r[i] != '0) begin
                        gap_s[i] = gap_r[i] - GAP_WIDTH'(1);
                    end else begin
                        state_s[i] = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (ch_valid[i]) begin
                        state_s[i] = fin_s[i] ? ST_DONE : ST_ACTIVE;
                    end else begin
                        state_s[i] = ST_ARMED;
                    end
                end
                ST_ACTIVE: begin
                    if (fin_s[i]) begin
                        state_s[i] = ST_DONE;
                    end else begin
                        state_s[i] = ST_ACTIVE;
                    end
                end
                default: begin
                    state_s[i] = state_r[i];
                end
            endcase

            active_s[i] = sat_inc(active_r[i], count_en_s[i]);
            xfer_s[i]   = sat_inc(xfer_r[i], count_en_s[i] & ch_valid[i] & ch_ready[i]);
            stall_s[i]  = sat_inc(stall_r[i], count_en_s[i] & ch_valid[i] & ~ch_ready[i]);
            sat_s[i]    = sat_r[i] |
                          (count_en_s[i] & ((&active_s[i]) | (&xfer_s[i]) | (&stall_s[i])));
        end
    end

    // State, gap and counter registers; flush only acts on enabled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_r <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i]  <= ST_WAIT;
                gap_r[i]    <= '0;
                active_r[i] <= '0;
                xfer_r[i]   <= '0;
                stall_r[i]  <= '0;
            end
        end else if (clk_en) begin
            if (flush) begin
                sat_r <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    state_r[i]  <= ST_WAIT;
                    gap_r[i]    <= '0;
                    active_r[i] <= '0;
                    xfer_r[i]   <= '0;
                    stall_r[i]  <= '0;
                end
            end else begin
                sat_r <= sat_s;
                for (int i = 0; i < NUM_CH; i++) begin
                    state_r[i]  <= state_s[i];
                    gap_r[i]    <= gap_s[i];
                    active_r[i] <= active_s[i];
                    xfer_r[i]   <= xfer_s[i];
                    stall_r[i]  <= stall_s[i];
                end
            end
        end else begin
            sat_r <= sat_r;
        end
    end

    // Readback mux: upper select bits pick the channel, low two bits the counter kind
    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cnt_sel >> 2) == i) begin
                case (cnt_sel[1:0])
                    2'd0:    cnt_out = active_r[i];
                    2'd1:    cnt_out = xfer_r[i];
                    2'd2:    cnt_out = stall_r[i];
                    2'd3:    cnt_out = CNT_WIDTH'({state_r[i], sat_r[i]});
                    default: cnt_out = '0;
                endcase
            end else begin
                cnt_out = cnt_out;
            end
        end
    end

endmodule

// File: tb/tb_stream_phase_monitor.sv
// Directed self-checking bench for stream_phase_monitor: lifecycle, backpressure, phase
// ordering with gap, clk_en gating, flush, async reset and counter saturation.
module tb_stream_phase_monitor;

    localparam logic [16:0] DT = 17'h10100;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        flush;
    logic [67:0] ch_data;
    logic [3:0]  ch_valid;
    logic [3:0]  ch_ready;
    logic [15:0] dep_mask;
    logic [31:0] gap_cycles;
    logic [3:0]  cnt_sel;
    logic [31:0] cnt_out;
    logic [7:0]  ch_state;
    logic [3:0]  ch_done;
    logic        all_done;

    logic [16:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_cnt_sel;
    logic [3:0]  s_cnt_out;
    logic [1:0]  s_state;
    logic        s_done;
    logic        s_all_done;

    int checks = 0;
    int errors = 0;

    stream_phase_monitor dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
        .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .dep_mask(dep_mask), .gap_cycles(gap_cycles), .cnt_sel(cnt_sel),
        .cnt_out(cnt_out), .ch_state(ch_state), .ch_done(ch_done), .all_done(all_done)
    );

    stream_phase_monitor #(.NUM_CH(1), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clk_en(1'b1), .flush(1'b0),
        .ch_data(s_data), .ch_valid(s_valid), .ch_ready(s_ready),
        .dep_mask(1'b0), .gap_cycles(8'h00), .cnt_sel(s_cnt_sel),
        .cnt_out(s_cnt_out), .ch_state(s_state), .ch_done(s_done), .all_done(s_all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int ch, input int kind, input logic [31:0] exp);
        cnt_sel = 4'(ch * 4 + kind);
        #1;
        check(tag, cnt_out, exp);
    endtask

    task automatic chk_sat(input string tag, input int kind, input logic [31:0] exp);
        s_cnt_sel = 2'(kind);
        #1;
        check(tag, {28'h0, s_cnt_out}, exp);
    endtask

    task automatic set_ch(input int ch, input logic v, input logic r, input logic [16:0] d);
        ch_valid[ch]         = v;
        ch_ready[ch]         = r;
        ch_data[ch*17 +: 17] = d;
    endtask

    logic [16:0] bp_data [8];
    logic        bp_rdy  [8];

    initial begin
        bp_data = '{17'h1, 17'h2, 17'h3, 17'h3, 17'h3, 17'h3, 17'h4, DT};
        bp_rdy  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0;
        ch_data = '0; ch_valid = '0; ch_ready = '0;
        dep_mask = 16'h0010;          // ch1 waits on ch0
        gap_cycles = 32'h0000_0400;   // ch1 gap = 4
        cnt_sel = 4'h0;
        s_data = 17'h0; s_valid = 1'b0; s_ready = 1'b0; s_cnt_sel = 2'd0;
        set_ch(1, 1'b1, 1'b0, 17'h00055);

        // Reset state
        #2;
        check("rst_state", {24'h0, ch_state}, 32'h0);
        check("rst_done", {28'h0, ch_done}, 32'h0);
        check("rst_all_done", {31'h0, all_done}, 32'h0);
        chk_cnt("rst_cnt", 0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arm_first_edge", {24'h0, ch_state}, 32'h51);

        // Single channel, 5 tokens then DONE
        for (int k = 1; k <= 5; k++) begin
            set_ch(0, 1'b1, 1'b1, 17'(k));
            tick();
        end
        check("ch0_active_state", {30'h0, ch_state[1:0]}, 32'h2);
        set_ch(0, 1'b1, 1'b1, DT);
        tick();
        set_ch(0, 1'b0, 1'b0, 17'h0);
        check("ch0_done", {28'h0, ch_done}, 32'h1);
        chk_cnt("ch0_active", 0, 0, 32'd6);
        chk_cnt("ch0_xfer", 0, 1, 32'd6);
        chk_cnt("ch0_stall", 0, 2, 32'd0);
        check("ch1_wait_at_t", {30'h0, ch_state[3:2]}, 32'h0);
        chk_cnt("ch1_wait_active", 1, 0, 32'd0);

        // Phase ordering: ch1 arms after edge t+5
        repeat (4) tick();
        check("ch1_wait_t4", {30'h0, ch_state[3:2]}, 32'h0);
        chk_cnt("ch1_wait_stall", 1, 2, 32'd0);
        tick();
        check("ch1_armed_t5", {30'h0, ch_state[3:2]}, 32'h1);
        chk_cnt("ch1_armed_active", 1, 0, 32'd0);
        tick();
        check("ch1_active_t6", {30'h0, ch_state[3:2]}, 32'h2);
        chk_cnt("ch1_active_cnt", 1, 0, 32'd1);
        chk_cnt("ch1_stall_cnt", 1, 2, 32'd1);
        chk_cnt("ch1_xfer_cnt", 1, 1, 32'd0);
        set_ch(1, 1'b1, 1'b1, DT);
        tick();
        set_ch(1, 1'b0, 1'b0, 17'h0);
        check("ch1_done", {30'h0, ch_state[3:2]}, 32'h3);
        chk_cnt("ch1_active_final", 1, 0, 32'd2);
        chk_cnt("ch1_xfer_final", 1, 1, 32'd1);

        // Backpressure on ch2
        for (int k = 0; k < 8; k++) begin
            set_ch(2, 1'b1, bp_rdy[k], bp_data[k]);
            tick();
        end
        set_ch(2, 1'b0, 1'b0, 17'h0);
        check("ch2_done", {30'h0, ch_state[5:4]}, 32'h3);
        chk_cnt("bp_xfer", 2, 1, 32'd5);
        chk_cnt("bp_stall", 2, 2, 32'd3);
        chk_cnt("bp_active", 2, 0, 32'd8);

        // clk_en gating on ch3; flush and a DONE token are ignored while disabled
        set_ch(3, 1'b1, 1'b1, 17'h7);
        tick();
        tick();
        set_ch(0, 1'b1, 1'b1, 17'h9);
        set_ch(3, 1'b1, 1'b1, DT);
        clk_en = 1'b0;
        flush  = 1'b1;
        repeat (10) tick();
        flush = 1'b0;
        check("gate_state", {30'h0, ch_state[7:6]}, 32'h2);
        chk_cnt("gate_active", 3, 0, 32'd2);
        chk_cnt("gate_xfer", 3, 1, 32'd2);
        check("gate_done_vec", {28'h0, ch_done}, 32'h7);
        clk_en = 1'b1;
        tick();
        check("all_done", {31'h0, all_done}, 32'h1);
        check("all_state", {24'h0, ch_state}, 32'hFF);
        chk_cnt("ch3_active_final", 3, 0, 32'd3);
        chk_cnt("ch0_after_done", 0, 0, 32'd6);

        // Flush out of the all-DONE state
        ch_valid = '0; ch_ready = '0; ch_data = '0;
        dep_mask = 16'h0000;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush1_state", {24'h0, ch_state}, 32'h0);
        check("flush1_all_done", {31'h0, all_done}, 32'h0);
        chk_cnt("flush1_cnt", 3, 0, 32'd0);
        tick();
        check("rearm", {24'h0, ch_state}, 32'h55);

        // Flush during ACTIVE
        set_ch(0, 1'b1, 1'b0, 17'h3);
        tick();
        tick();
        chk_cnt("pre_flush_stall", 0, 2, 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush2_state", {24'h0, ch_state}, 32'h0);
        chk_cnt("flush2_active", 0, 0, 32'd0);
        chk_cnt("flush2_stall", 0, 2, 32'd0);

        // Asynchronous reset mid-cycle
        tick();
        tick();
        chk_cnt("pre_rst_active", 0, 0, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", {24'h0, ch_state}, 32'h0);
        chk_cnt("async_rst_active", 0, 0, 32'd0);
        set_ch(0, 1'b0, 1'b0, 17'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation on the 4-bit counter instance
        tick();
        s_valid = 1'b1; s_ready = 1'b1; s_data = 17'h1;
        repeat (10) tick();
        chk_sat("sat_active_10", 0, 32'd10);
        chk_sat("sat_flag_clear", 3, 32'd4);
        repeat (10) tick();
        chk_sat("sat_active_20", 0, 32'd15);
        chk_sat("sat_xfer_20", 1, 32'd15);
        chk_sat("sat_stall_20", 2, 32'd0);
        chk_sat("sat_flag_set", 3, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_phase_monitor.md
# stream_phase_monitor

Passive, synthesisable monitor for the fiber-access unit-test harness and on-chip debug. It observes NUM_CH ready/valid token streams (coordinate, position, block, write-scanner streams), tracks each channel through an arm → active → done lifecycle terminated by the DONE token, and keeps per-channel active, transfer and stall cycle counts. Per-channel dependency masks and gap counters generalise the harness rule "the read phase starts only after the write phase has finished and a gap has elapsed" to any number of channels and phases. It never drives the observed streams.

## Interface
- NUM_CH, 4: number of observed channels (1–16).
- DATA_WIDTH, 17: stream token width.
- CNT_WIDTH, 32: counter width.
- GAP_WIDTH, 8: width of each per-channel gap value.
- DONE_TOKEN, 17'h10100: end-of-stream token value, compared over DATA_WIDTH bits.

Ports:
- clk  in  1  Single clock.
- rst_n  in  1  Asynchronous, active-low reset.
- clk_en  in  1  When low, all state and counters hold.
- flush  in  1  Synchronous clear to the reset state; takes priority over all other updates.
- ch_data  in  NUM_CH*DATA_WIDTH  Observed tokens; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ch_valid  in  NUM_CH  Observed valid signals.
- ch_ready  in  NUM_CH  Observed ready signals.
- dep_mask  in  NUM_CH*NUM_CH  Row i: set of channels that must reach DONE before channel i arms. Bit i of row i is ignored.
- gap_cycles  in  NUM_CH*GAP_WIDTH  Per-channel wait, in cycles, after its dependencies complete.
- cnt_sel  in  $clog2(NUM_CH)+2  Readback select: {channel, kind}. Kind 0 = active cycles, 1 = transfers, 2 = stalls, 3 = {state, saturated flag}, zero-extended.
- cnt_out  out  CNT_WIDTH  Combinational readback of the selected counter.
- ch_state  out  2*NUM_CH  Per-channel state encoding.
- ch_done  out  NUM_CH  High while the channel is in DONE.
- all_done  out  1  AND of ch_done.

## Operation
- Per-channel states:
  - WAIT (0): reset state.
  - ARMED (1).
  - ACTIVE (2).
  - DONE (3).
- Transfer: xfer_i = valid_i & ready_i.
- WAIT → ARMED:
  - Condition: all dependency channels are DONE and the gap counter is zero.
  - The gap counter loads gap_cycles_i while any dependency is not DONE. It decrements on each enabled cycle once all dependencies are DONE.
  - A channel with an empty mask and gap 0 goes to ARMED on the first enabled cycle after reset.
- ARMED → ACTIVE: on the first enabled cycle with valid_i = 1. That cycle is counted, as are its transfer and stall.
- Valid asserted while the channel is in WAIT is ignored; nothing is counted.
- ACTIVE, each enabled cycle:
  - active += 1.
  - xfer += xfer_i.
  - stall += valid_i & ~ready_i.
- ACTIVE → DONE: on an xfer with data == DONE_TOKEN. That cycle is counted.
- DONE is terminal until flush or reset. All later activity on the channel is ignored.
- An ARMED-cycle DONE-token transfer goes ARMED → DONE directly; all counters = 1 (active, xfer), stall = 0.
- Counters saturate at all-ones. A sticky saturated flag is set per channel if any of its counters saturated.
- Dependency cycles (e.g. A depends on B, B depends on A) deadlock in WAIT. This is legal; the channels simply never arm.

## Timing
- Reset (async) and flush (sync) set:
  - all states = WAIT
  - all counters = 0
  - gap counters = 0
  - saturated flags = 0
  - ch_done = 0
  - all_done = 0 (with NUM_CH ≥ 1)
- First enabled edge after reset performs the WAIT evaluation. Gap counters start at 0, so a channel whose dependencies are already satisfied arms with no gap. Gap loading applies only while dependencies are pending.
- Dependency completion seen at edge t, gap g:
  - ARMED after edge t+g+1 (gap counter loaded up to edge t, decremented g times).
- State and counter updates are registered. ch_state, ch_done and all_done reflect the state after the edge.
- cnt_out is combinational from registers plus cnt_sel; it has no extra latency.
- clk_en low: no state change, no counting, gap counters hold. Observed handshakes in that cycle are not counted.
- flush and clk_en: flush acts only when clk_en is high.
- Simultaneous completion of the last dependency and a DONE token on another channel: each channel is evaluated independently with its own pre-edge state; there is no combinational chaining within a cycle.

## Test plan
- Single channel, empty mask, gap 0:
  - Stimulus: 5 tokens then DONE_TOKEN, ready always 1, no bubbles.
  - Required: active = 6, xfer = 6, stall = 0, ch_done[0] high after the DONE transfer edge.
- Backpressure:
  - Stimulus: ready low 3 cycles mid-stream on 4 tokens + DONE.
  - Required: xfer = 5, stall = 3, active = 8.
- Phase ordering:
  - Setup: ch1 depends on ch0, gap_cycles[1] = 4.
  - Stimulus: ch1 valid high from reset; ch0 completes at edge t.
  - Required: ch1 stays WAIT with zero counts, ARMED after edge t+5, ACTIVE on the next valid cycle.
- Saturation:
  - Setup: CNT_WIDTH = 4.
  - Stimulus: 20 active cycles.
  - Required: active = 15, saturated flag = 1 via kind 3.
- Flush and reset mid-stream:
  - Stimulus: flush during ACTIVE with clk_en = 1.
  - Required: all counters 0 and state WAIT next cycle.
  - Stimulus: async rst_n low mid-cycle.
  - Required: outputs clear immediately, without waiting for a clock edge.
- clk_en gating and all_done:
  - Stimulus: clk_en low for 10 cycles during ACTIVE.
  - Required: counts unchanged across the window.
  - Stimulus: all 4 channels complete.
  - Required: all_done = 1.
